outp_ctrl: RTL and testbench

//  Sequential controller for the OUT display path. Samples saidaUla when the control

---
 rtl/outp_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_outp_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/outp_ctrl.sv
// outp_ctrl: OUT display-path controller.
// Captures the ALU result on an OUT strobe, converts the low IN_BITS bits to
// BCD with the shift-add-3 algorithm (one bit per clock) and holds the result
// on four registered digit outputs. One request can wait while a conversion
// is in flight; the newest waiting request replaces an older one.
module outp_ctrl #(
  parameter int         IN_BITS = 16,
  parameter logic [3:0] BLANK   = 4'hF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        out,
  input  logic [31:0] saidaUla,
  input  logic        halt,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic        halted,
  output logic [3:0]  mil,
  output logic [3:0]  cent,
  output logic [3:0]  dez,
  output logic [3:0]  uni
);

  localparam int                CNT_W    = $clog2(IN_BITS + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(IN_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Add 3 to every nibble that is 5 or more, ahead of the next left shift.
  function automatic logic [19:0] bcd_adjust(input logic [19:0] v);
    logic [19:0] r;
    r = v;
    for (int i = 0; i < 5; i++) begin
      if (v[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Any bit above the converted field makes the value undisplayable.
  function automatic logic upper_set(input logic [31:0] v);
    return (v >> IN_BITS) != 32'd0;
  endfunction

  state_t               state_r;
  state_t               state_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [IN_BITS-1:0]   shreg_r;
  logic [19:0]          bcd_r;
  logic [19:0]          bcd_adj_s;
  logic                 hi_r;
  logic [31:0]          pend_val_r;
  logic                 pend_v_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 ovf_r;
  logic                 halted_r;
  logic [15:0]          digits_r;

  logic                 accept_s;
  logic                 start_s;
  logic [31:0]          start_val_s;
  logic                 pend_wr_s;
  logic                 pend_clr_s;
  logic                 shift_s;
  logic                 finish_s;

  assign accept_s  = out & ~halt;
  assign bcd_adj_s = bcd_adjust(bcd_r);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s || pend_v_r) begin
          state_s = ST_SHIFT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_r == CNT_LAST) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (pend_v_r || accept_s) begin
          state_s = ST_SHIFT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Per-state datapath controls: load, shift, finish and pending-slot updates.
  always_comb begin
    start_s     = 1'b0;
    start_val_s = 32'd0;
    pend_wr_s   = 1'b0;
    pend_clr_s  = 1'b0;
    shift_s     = 1'b0;
    finish_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          start_s     = 1'b1;
          start_val_s = saidaUla;
        end else if (pend_v_r) begin
          start_s     = 1'b1;
          start_val_s = pend_val_r;
          pend_clr_s  = 1'b1;
        end else begin
          start_s     = 1'b0;
        end
      end
      ST_SHIFT: begin
        shift_s = 1'b1;
        if (accept_s) begin
          pend_wr_s = 1'b1;
        end else begin
          pend_wr_s = 1'b0;
        end
      end
      ST_DONE: begin
        finish_s = 1'b1;
        if (pend_v_r) begin
          // Waiting request starts now; a new strobe takes the freed slot.
          start_s     = 1'b1;
          start_val_s = pend_val_r;
          if (accept_s) begin
            pend_wr_s = 1'b1;
          end else begin
            pend_clr_s = 1'b1;
          end
        end else if (accept_s) begin
          // Request arriving with an empty slot starts straight away.
          start_s     = 1'b1;
          start_val_s = saidaUla;
        end else begin
          start_s     = 1'b0;
        end
      end
      default: begin
        start_s = 1'b0;
      end
    endcase
  end

  // Pending request slot; the newest request overwrites an older one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_val_r <= 32'd0;
      pend_v_r   <= 1'b0;
    end else if (pend_wr_s) begin
      pend_val_r <= saidaUla;
      pend_v_r   <= 1'b1;
    end else if (pend_clr_s) begin
      pend_v_r   <= 1'b0;
    end else begin
      pend_v_r   <= pend_v_r;
    end
  end

  // Conversion datapath: load a new value or perform one shift-add-3 step.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shreg_r <= '0;
      bcd_r   <= 20'd0;
      cnt_r   <= '0;
      hi_r    <= 1'b0;
    end else if (start_s) begin
      shreg_r <= start_val_s[IN_BITS-1:0];
      bcd_r   <= 20'd0;
      cnt_r   <= '0;
      hi_r    <= upper_set(start_val_s);
    end else if (shift_s) begin
      bcd_r   <= {bcd_adj_s[18:0], shreg_r[IN_BITS-1]};
      shreg_r <= {shreg_r[IN_BITS-2:0], 1'b0};
      cnt_r   <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r   <= cnt_r;
    end
  end

  // Display registers: update only when a conversion finishes, otherwise hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done_r   <= 1'b0;
      ovf_r    <= 1'b0;
      digits_r <= {BLANK, BLANK, BLANK, BLANK};
    end else if (finish_s) begin
      done_r <= 1'b1;
      if (hi_r || (bcd_r[19:16] != 4'd0)) begin
        ovf_r    <= 1'b1;
        digits_r <= {BLANK, BLANK, BLANK, BLANK};
      end else begin
        ovf_r    <= 1'b0;
        digits_r <= bcd_r[15:0];
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  // Status flags: busy follows the upcoming state, halted needs an idle, empty controller.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_r   <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      busy_r   <= (state_s != ST_IDLE);
      halted_r <= halt & (state_r == ST_IDLE) & ~pend_v_r;
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign ovf    = ovf_r;
  assign halted = halted_r;
  assign mil    = digits_r[15:12];
  assign cent   = digits_r[11:8];
  assign dez    = digits_r[7:4];
  assign uni    = digits_r[3:0];

endmodule

// File: tb/tb_outp_ctrl.sv
// Self-checking bench for outp_ctrl: table-driven conversions plus
// hand-written sequences for pending requests, mid-conversion reset and halt.
module tb_outp_ctrl;

  logic        clock;
  logic        reset;
  logic        out;
  logic [31:0] saidaUla;
  logic        halt;
  logic        busy;
  logic        done;
  logic        ovf;
  logic        halted;
  logic [3:0]  mil, cent, dez, uni;

  int total;
  int bad;

  outp_ctrl dut (
    .clock(clock), .reset(reset), .out(out), .saidaUla(saidaUla), .halt(halt),
    .busy(busy), .done(done), .ovf(ovf), .halted(halted),
    .mil(mil), .cent(cent), .dez(dez), .uni(uni)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] val;
    logic [15:0] exp_dig;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Wait for done, counting edges; a timeout is a failed comparison.
  task automatic wait_done(input string name, input int limit, output int n);
    bit seen;
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      n++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_seen"}, {31'd0, seen}, 32'd1);
  endtask

  // Drive a one-cycle OUT strobe; returns just after the accept edge.
  task automatic strobe(input logic [31:0] v);
    out = 1'b1;
    saidaUla = v;
    tick();
    out = 1'b0;
  endtask

  initial begin
    int n;
    int busy_cnt;
    int done_cnt;
    total = 0;
    bad = 0;
    reset = 1'b1;
    out = 1'b0;
    halt = 1'b0;
    saidaUla = 32'd0;

    vecs[0] = '{32'd1234,      16'h1234, 1'b0};
    vecs[1] = '{32'd0,         16'h0000, 1'b0};
    vecs[2] = '{32'd9,         16'h0009, 1'b0};
    vecs[3] = '{32'd9999,      16'h9999, 1'b0};
    vecs[4] = '{32'd10000,     16'hFFFF, 1'b1};
    vecs[5] = '{32'd65535,     16'hFFFF, 1'b1};
    vecs[6] = '{32'h0001_0000, 16'hFFFF, 1'b1};
    vecs[7] = '{32'hFFFF_FFFF, 16'hFFFF, 1'b1};

    // 1: reset state and idle
    tick();
    tick();
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) done_cnt++;
    end
    chk("rst_digits", {16'd0, mil, cent, dez, uni}, 32'h0000_FFFF);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_done_cnt", done_cnt, 32'd0);

    // 2-4: table of single conversions
    for (int v = 0; v < 8; v++) begin
      strobe(vecs[v].val);
      busy_cnt = (busy === 1'b1) ? 1 : 0;
      n = 0;
      for (int i = 0; i < 40; i++) begin
        tick();
        n++;
        if (busy === 1'b1) busy_cnt++;
        if (done) break;
      end
      chk($sformatf("v%0d_latency", v), n, 32'd17);
      chk($sformatf("v%0d_busy", v), busy_cnt, 32'd17);
      chk($sformatf("v%0d_digits", v), {16'd0, mil, cent, dez, uni}, {16'd0, vecs[v].exp_dig});
      chk($sformatf("v%0d_ovf", v), {31'd0, ovf}, {31'd0, vecs[v].exp_ovf});
      tick();
      chk($sformatf("v%0d_done_pulse", v), {31'd0, done}, 32'd0);
      tick();
    end

    // 5: pending request overwritten by a newer one
    strobe(32'd12);            // edge E
    tick();
    tick();                    // E+2
    strobe(32'd34);            // E+3
    tick();                    // E+4
    strobe(32'd56);            // E+5
    wait_done("p1", 30, n);
    chk("p1_latency", n, 32'd12);
    chk("p1_digits", {16'd0, mil, cent, dez, uni}, 32'h0000_0012);
    wait_done("p2", 30, n);
    chk("p2_latency", n, 32'd17);
    chk("p2_digits", {16'd0, mil, cent, dez, uni}, 32'h0000_0056);
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) done_cnt++;
    end
    chk("p_extra_done", done_cnt, 32'd0);
    chk("p_hold_digits", {16'd0, mil, cent, dez, uni}, 32'h0000_0056);

    // 6: reset in the middle of a conversion
    strobe(32'd4321);          // edge E
    for (int i = 0; i < 8; i++) tick();
    reset = 1'b1;
    #1;
    chk("mr_digits", {16'd0, mil, cent, dez, uni}, 32'h0000_FFFF);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    tick();
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) done_cnt++;
    end
    chk("mr_no_done", done_cnt, 32'd0);
    strobe(32'd7);
    wait_done("mr_next", 30, n);
    chk("mr_next_latency", n, 32'd17);
    chk("mr_next_digits", {16'd0, mil, cent, dez, uni}, 32'h0000_0007);

    // 7: halt during a conversion; the OUT strobe under halt is dropped
    tick();
    strobe(32'd88);            // edge E
    halt = 1'b1;               // seen from E+1 onward
    tick();
    tick();
    tick();                    // E+3
    strobe(32'd99);            // ignored at E+4
    wait_done("h", 30, n);
    chk("h_latency", n, 32'd13);
    chk("h_digits", {16'd0, mil, cent, dez, uni}, 32'h0000_0088);
    tick();
    tick();
    chk("h_halted", {31'd0, halted}, 32'd1);
    chk("h_busy", {31'd0, busy}, 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done) done_cnt++;
    end
    chk("h_ignored", done_cnt, 32'd0);
    chk("h_hold_digits", {16'd0, mil, cent, dez, uni}, 32'h0000_0088);
    halt = 1'b0;
    tick();
    chk("h_release", {31'd0, halted}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
